// File: rtl/shift_sequencer.sv
// Command sequencer for a universal shift register: load / shift N / hold, with settle cycles.
// Optional feature: define SEQ_ABORT_EN to add an abort input that returns the FSM to IDLE.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
`ifdef SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] reg_data,
    output logic             left_in,
    output logic             right_in,
    output logic             busy,
    output logic             done,
    output logic [7:0]       op_count
);

    // state   | meaning
    // IDLE    | waiting for a command, cmd_ready=1, register retains
    // LOAD    | one cycle of parallel load (sel=00)
    // SHIFT   | shift_cnt cycles of left/right shift with the latched fill bit
    // SETTLE1 | first retain cycle, register output pipeline catching up
    // SETTLE2 | second retain cycle, register output valid, done=1
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        SETTLE1 = 3'd3,
        SETTLE2 = 3'd4
    } state_t;

    localparam logic [1:0] SEL_LOAD   = 2'b00;
    localparam logic [1:0] SEL_LEFT   = 2'b01;
    localparam logic [1:0] SEL_RIGHT  = 2'b10;
    localparam logic [1:0] SEL_RETAIN = 2'b11;

    state_t           state;
    logic [CNT_W-1:0] shift_cnt;

    // Outputs are registered alongside the state, so they change only on the clock edge.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_cnt <= '0;
            cmd_ready <= 1'b1;
            sel       <= SEL_RETAIN;
            reg_data  <= '0;
            left_in   <= 1'b0;
            right_in  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        case (cmd_op)
                            2'b00: begin
                                state    <= LOAD;
                                sel      <= SEL_LOAD;
                                reg_data <= cmd_data;
                            end
                            2'b01, 2'b10: begin
                                if (cmd_count != '0) begin
                                    state     <= SHIFT;
                                    sel       <= cmd_op;
                                    shift_cnt <= cmd_count;
                                    left_in   <= (cmd_op == SEL_LEFT) & cmd_fill;
                                    right_in  <= (cmd_op == SEL_RIGHT) & cmd_fill;
                                end else begin
                                    state <= SETTLE1;
                                end
                            end
                            default: state <= SETTLE1;
                        endcase
                    end
                end
                LOAD: begin
                    state <= SETTLE1;
                    sel   <= SEL_RETAIN;
                end
                SHIFT: begin
                    shift_cnt <= shift_cnt - 1'b1;
                    if (shift_cnt == CNT_W'(1)) begin
                        state    <= SETTLE1;
                        sel      <= SEL_RETAIN;
                        left_in  <= 1'b0;
                        right_in <= 1'b0;
                    end
                end
                SETTLE1: begin
                    state    <= SETTLE2;
                    done     <= 1'b1;
                    op_count <= op_count + 8'd1;
                end
                SETTLE2: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    sel       <= SEL_RETAIN;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
`ifdef SEQ_ABORT_EN
            // Abort wins over every transition above, including the op_count bump.
            if (abort && state != IDLE) begin
                state     <= IDLE;
                shift_cnt <= '0;
                sel       <= SEL_RETAIN;
                left_in   <= 1'b0;
                right_in  <= 1'b0;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                done      <= 1'b0;
                op_count  <= op_count;
            end
`endif
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: command-level timing model, per-cycle output compare, directed vectors.
// Exercises the abort input as well when SEQ_ABORT_EN is defined.
module tb_shift_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_fill = 1'b0;
`ifdef SEQ_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             cmd_ready;
    logic [1:0]       sel;
    logic [WIDTH-1:0] reg_data;
    logic             left_in, right_in, busy, done;
    logic [7:0]       op_count;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
`ifdef SEQ_ABORT_EN
        .abort(abort),
`endif
        .sel(sel), .reg_data(reg_data), .left_in(left_in), .right_in(right_in),
        .busy(busy), .done(done), .op_count(op_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Command-level model: one active command at a time, described by its
    // acceptance cycle, latency and shift window.
    int         cyc = 0;
    int         m_t = 0;
    int         m_end = 0;
    int         m_n = 0;
    logic       m_active = 1'b0;
    logic [1:0] m_op = 2'b00;
    logic       m_fill = 1'b0;
    logic [3:0] m_reg = 4'd0;
    logic [7:0] m_cnt = 8'd0;
    logic [3:0] u_int = 4'd0;
    logic [3:0] u_out = 4'd0;
    logic [1:0] e_sel = 2'b11;
    logic [3:0] e_rd = 4'd0;
    logic       e_l = 1'b0, e_r = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_ready = 1'b1;
    logic       chk_en = 1'b0;
    int         acc_q[$];
    int         done_cnt = 0;

    always @(posedge clock) begin
        int   prev;
        int   rel;
        logic ab;
        // Universal register with a one-cycle output stage, driven by the expected controls.
        u_out = u_int;
        case (e_sel)
            2'b00:   u_int = e_rd;
            2'b01:   u_int = {u_int[2:0], e_l};
            2'b10:   u_int = {e_r, u_int[3:1]};
            default: u_int = u_int;
        endcase
        if (rst_n && cmd_valid && cmd_ready) acc_q.push_back(cyc);
        prev = cyc;
        cyc  = cyc + 1;
        ab = 1'b0;
`ifdef SEQ_ABORT_EN
        ab = abort;
`endif
        if (!rst_n) begin
            m_active = 1'b0;
            m_reg    = 4'd0;
            m_cnt    = 8'd0;
            u_int    = 4'd0;
            u_out    = 4'd0;
        end else begin
            if (m_active && (prev == m_end || ab)) begin
                m_active = 1'b0;
            end else if (!m_active && cmd_valid) begin
                m_active = 1'b1;
                m_t      = prev;
                m_op     = cmd_op;
                m_n      = int'(cmd_count);
                m_fill   = cmd_fill;
                if (cmd_op == 2'b00) begin
                    m_reg = cmd_data;
                    m_end = prev + 3;
                end else if (cmd_op != 2'b11 && m_n > 0) begin
                    m_end = prev + m_n + 2;
                end else begin
                    m_end = prev + 2;
                end
            end
            if (m_active && cyc == m_end) m_cnt = m_cnt + 8'd1;
        end
        e_sel = 2'b11; e_l = 1'b0; e_r = 1'b0; e_done = 1'b0;
        e_busy = m_active; e_ready = !m_active; e_rd = m_reg;
        if (m_active) begin
            rel = cyc - m_t;
            if (m_op == 2'b00 && rel == 1) begin
                e_sel = 2'b00;
            end else if ((m_op == 2'b01 || m_op == 2'b10) && rel >= 1 && rel <= m_n) begin
                e_sel = m_op;
                if (m_op == 2'b01) e_l = m_fill;
                else               e_r = m_fill;
            end
            e_done = (cyc == m_end);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("sel",       32'(sel),       32'(e_sel));
            check("reg_data",  32'(reg_data),  32'(e_rd));
            check("left_in",   32'(left_in),   32'(e_l));
            check("right_in",  32'(right_in),  32'(e_r));
            check("busy",      32'(busy),      32'(e_busy));
            check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            check("done",      32'(done),      32'(e_done));
            check("op_count",  32'(op_count),  32'(m_cnt));
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic issue(input logic [1:0] op, input int cnt, input logic [3:0] data,
                         input logic fill, input int exp_lat, input string name);
        int   t;
        logic got;
        @(negedge clock);
        cmd_op = op; cmd_count = CNT_W'(cnt); cmd_data = data; cmd_fill = fill;
        cmd_valid = 1'b1;
        t = cyc;
        @(negedge clock);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (done === 1'b1) got = 1'b1;
            else @(negedge clock);
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
        else      check({name, "_latency"}, 32'(cyc - t), 32'(exp_lat));
    endtask

    initial begin
        int d0;
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        logic got;
        rst_n = 1'b0;
        @(posedge clock);
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_ready",   32'(cmd_ready), 32'd1);
        check("rst_sel",     32'(sel),       32'd3);
        check("rst_opcount", 32'(op_count),  32'd0);
        check("rst_regdata", 32'(reg_data),  32'd0);
        rst_n = 1'b1;

        issue(2'b00, 0, 4'b1011, 1'b0, 3, "load");
        check("load_regdata", 32'(reg_data), 32'hB);
        check("load_opcount", 32'(op_count), 32'd1);
        check("model_load_reg", 32'(u_out), 32'hB);

        issue(2'b01, 3, 4'b0000, 1'b1, 5, "shl3");
        check("model_shl_reg", 32'(u_out), 32'hF);

        issue(2'b10, 2, 4'b0000, 1'b0, 4, "shr2");
        check("model_shr_reg", 32'(u_out), 32'h3);

        issue(2'b10, 0, 4'b0000, 1'b1, 2, "zero_cnt");
        issue(2'b11, 5, 4'b1111, 1'b1, 2, "hold");
        check("hold_opcount",  32'(op_count), 32'd5);
        check("hold_regdata",  32'(reg_data), 32'hB);
        check("model_opcount", 32'(m_cnt),    32'd5);

        for (int i = 0; i < 249; i++) issue(2'b11, 0, 4'b0000, 1'b0, 2, "fill_hold");
        check("pre_wrap_opcount", 32'(op_count), 32'd254);

        // Three loads with cmd_valid held high.
        acc_q.delete();
        @(negedge clock);
        cmd_op = 2'b00; cmd_data = 4'b0101; cmd_valid = 1'b1;
        repeat (9) @(negedge clock);
        cmd_valid = 1'b0;
        check("b2b_accepts", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() == 3) begin
            check("b2b_gap1", 32'(acc_q[1] - acc_q[0]), 32'd4);
            check("b2b_gap2", 32'(acc_q[2] - acc_q[1]), 32'd4);
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (done === 1'b1) got = 1'b1;
            else @(negedge clock);
        end
        check("b2b_done_seen", 32'(got), 32'd1);
        check("wrap_opcount", 32'(op_count), 32'd1);
        check("b2b_regdata",  32'(reg_data), 32'h5);

        // Reset in the middle of a 7-cycle shift.
        @(negedge clock);
        @(negedge clock);
        cmd_op = 2'b01; cmd_count = 3'd7; cmd_fill = 1'b1; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        check("midshift_sel", 32'(sel), 32'd1);
        @(negedge clock);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clock);
        check("rst_mid_sel",     32'(sel),      32'd3);
        check("rst_mid_busy",    32'(busy),     32'd0);
        check("rst_mid_opcount", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clock);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        repeat (10) @(negedge clock);
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef SEQ_ABORT_EN
        @(negedge clock);
        cmd_op = 2'b01; cmd_count = 3'd5; cmd_fill = 1'b1; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        d0 = done_cnt;
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy",    32'(busy),      32'd0);
        check("abort_ready",   32'(cmd_ready), 32'd1);
        check("abort_sel",     32'(sel),       32'd3);
        check("abort_opcount", 32'(op_count),  32'd0);
        repeat (8) @(negedge clock);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
`endif

        issue(2'b00, 0, 4'b0110, 1'b0, 3, "load_after_rst");
        check("final_opcount", 32'(op_count), 32'd1);
        check("final_regdata", 32'(reg_data), 32'h6);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
